// File: rtl/lookahead_adder_pipe.sv
// Pipelined hierarchical carry-lookahead adder/subtractor, one SLICE-bit slice per stage.
// Optional {V,N,Z} flag output enabled by defining LOOKAHEAD_ADDER_PIPE_FLAGS_EN.
module lookahead_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef LOOKAHEAD_ADDER_PIPE_FLAGS_EN
  ,
  output logic [2:0]       out_flags
`endif
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int NG     = SLICE / 4;

  // One slice: 4-bit groups with internal lookahead, group carries from a flat lookahead of group P/G.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE-1:0] p, g, s;
    logic [NG-1:0]    gp, gg;
    logic [NG:0]      gc;
    logic [3:0]       p4, g4, c4;
    logic             acc, prod;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NG; j++) begin
      p4 = p[4*j +: 4];
      g4 = g[4*j +: 4];
      gp[j] = &p4;
      gg[j] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
    end
    gc[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      for (int i = 0; i < j; i++) begin
        prod = gg[i];
        for (int m = i + 1; m < j; m++) prod = prod & gp[m];
        acc = acc | prod;
      end
      prod = cin;
      for (int m = 0; m < j; m++) prod = prod & gp[m];
      gc[j] = acc | prod;
    end
    for (int j = 0; j < NG; j++) begin
      p4 = p[4*j +: 4];
      g4 = g[4*j +: 4];
      c4[0] = gc[j];
      c4[1] = g4[0] | (p4[0] & gc[j]);
      c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & gc[j]);
      c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & gc[j]);
      s[4*j +: 4] = p4 ^ c4;
    end
    return {gc[NG], s};
  endfunction

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d, v_q, v_d;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c, src_v;
  logic [SLICE:0]    slice_r [STAGES];
  logic              stall;

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];

  // Stage inputs: stage 0 takes the (subtract-adjusted) operands, later stages the previous stage's registers.
  always_comb begin
    src_a[0] = in_a;
    src_b[0] = in_sub ? ~in_b : in_b;
    src_c[0] = in_sub ? 1'b1 : in_cin;
    src_v[0] = in_valid;
    src_s[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  // Next state per stage; a stall freezes every register including valid bits.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_r[k] = cla_slice(src_a[k][k*SLICE +: SLICE], src_b[k][k*SLICE +: SLICE], src_c[k]);
      if (stall) begin
        a_d[k] = a_q[k];
        b_d[k] = b_q[k];
        s_d[k] = s_q[k];
        c_d[k] = c_q[k];
        v_d[k] = v_q[k];
      end else begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
        s_d[k] = src_s[k];
        s_d[k][k*SLICE +: SLICE] = slice_r[k][SLICE-1:0];
        c_d[k] = slice_r[k][SLICE];
        v_d[k] = src_v[k];
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
        s_q[k] <= {WIDTH{1'b0}};
      end
      c_q <= {STAGES{1'b0}};
      v_q <= {STAGES{1'b0}};
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_d;
    end
  end

`ifdef LOOKAHEAD_ADDER_PIPE_FLAGS_EN
  logic [2:0]       flags_d, flags_q;
  logic [WIDTH-1:0] fsum;

  // Flags come from the operand signs of the top slice and the fully assembled sum.
  always_comb begin
    fsum = s_d[STAGES-1];
    if (stall) begin
      flags_d = flags_q;
    end else begin
      flags_d[2] = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &
                   (fsum[WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
      flags_d[1] = fsum[WIDTH-1];
      flags_d[0] = (fsum == {WIDTH{1'b0}});
    end
  end

  // Flag register, aligned with out_sum.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_flags = flags_q;
`endif

endmodule

// File: doc/lookahead_adder_pipe.md
# lookahead_adder_pipe

Parametrised, pipelined hierarchical carry-lookahead adder/subtractor. Operands are split into SLICE-bit slices; each pipeline stage resolves one slice with a 4-bit-group lookahead tree and registers the carry into the next stage. The block replaces the fixed 16-bit combinational adder wherever wide (32/64-bit) arithmetic must meet timing. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 16, bits resolved per stage; must be a multiple of 4. STAGES = WIDTH/SLICE.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add only).
- in_sub  in  1  0 = A+B+cin; 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out (for subtraction, 1 = no borrow).
- out_flags  out  3  {V,N,Z}; present only with the macro (see Configuration).

## Operation
- The clock is Clk only. Reset is synchronous and active-high.
- Effective B = in_sub ? ~in_b : in_b. Effective slice-0 carry = in_sub ? 1 : in_cin.
- Stage k (0..STAGES−1) computes slice k as sum = A_k + B_k + c_k using 4-bit groups with P/G and group lookahead. It does not use a ripple between groups. The slice carry-out becomes c_{k+1} and is registered.
- Slices not yet consumed travel down the pipe with the beat. Slices already summed are held in per-stage result registers, so the full sum is assembled at the last stage.
- out_cout is the carry-out of the top slice. The result is modulo 2^WIDTH.
- Pipe-wide stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, every stage register holds, including valid bits.
  - Bubbles are not compacted.
- A beat is accepted when in_valid & in_ready at a rising edge. A result is consumed when out_valid & out_ready.
- Each stage carries a valid bit. A stage with valid=0 still updates its data registers, but the bubble never shows as out_valid.
- Ordering is strictly FIFO. No beats are dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N shows on out_* with out_valid=1 after edge N+STAGES−1, i.e. STAGES register levels. With WIDTH=32 and SLICE=16, results appear 2 edges after acceptance (edges N and N+1).
- Throughput is one beat per cycle when out_ready=1.
- out_* are driven straight from registers, with no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready.
- While out_valid=1 and out_ready=0, out_sum, out_cout and out_flags hold stable.
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_flags=0, all stage valid bits 0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. No result from before the reset is ever presented. Reset overrides stall and in_valid in the same cycle.
- Accept and emit in the same cycle (pipe full, out_ready=1): both take effect, and occupancy is unchanged.
- A carry crossing a slice boundary takes exactly one extra register level. It is never resolved combinationally across stages.

## Configuration
- Macro: LOOKAHEAD_ADDER_PIPE_FLAGS_EN.
- Defined:
  - out_flags exists and is registered with out_sum.
  - V = signed overflow: (A_msb == B_eff_msb) & (sum_msb != A_msb).
  - N = sum_msb.
  - Z = (sum == 0).
- Undefined:
  - The out_flags port and its logic are absent.
  - All other behaviour and latency are identical.

## Test plan
(WIDTH=32, SLICE=16, macro defined unless noted.)
- Add with carry chain: A=0xFFFF_FFFF, B=0x1, cin=0, sub=0 → 2 edges later sum=0x0000_0000, cout=1, flags Z=1, V=0.
- Slice-boundary carry: A=0x0000_FFFF, B=0x0000_0001 → sum=0x0001_0000, cout=0.
- Signed overflow: A=0x7FFF_FFFF, B=0x1 → sum=0x8000_0000, V=1, N=1. Subtraction: A=5, B=7, sub=1 → sum=0xFFFF_FFFE, cout=0, N=1, V=0.
- Backpressure: three beats back-to-back (1+1, 2+2, 3+3) with out_ready held low for 2 cycles after the first result appears:
  - in_ready=0 during the stall.
  - out_sum holds 0x2 stable.
  - Results then emerge 0x2, 0x4, 0x6 in order, with none lost.
- Reset flush: Reset asserted for one cycle with 2 beats in flight → out_valid=0 from the next edge. Neither beat ever appears. A new beat 0x10+0x20 afterwards yields 0x30 after 2 edges.
- Build without the macro: rerun the first scenario → sum/cout and latency match, and out_flags is absent.
